// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
// Widths here describe the default core configuration.
package regfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_NREG   = 32;
    localparam int RF_AW     = $clog2(RF_NREG);
    localparam int RF_NRP    = 3;
    localparam int RF_NWP    = 2;
    localparam int RF_SP_IDX = 29;
    localparam logic [RF_DATA_W-1:0] RF_SP_INIT = 32'h100;

    typedef logic [RF_AW-1:0]     reg_addr_t;
    typedef logic [RF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Register file access bundle: write ports, read ports, scoreboard control.
// master drives requests, slave is the register file.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int NREG   = RF_NREG,
    parameter int NRP    = RF_NRP,
    parameter int NWP    = RF_NWP,
    localparam int AW    = $clog2(NREG)
);

    logic [NWP-1:0]             we;
    logic [NWP-1:0][AW-1:0]     wa;
    logic [NWP-1:0][DATA_W-1:0] wd;
    logic [NRP-1:0][AW-1:0]     ra;
    logic [NRP-1:0][DATA_W-1:0] rd;
    logic [NRP-1:0]             rdy;
    logic                       alloc_en;
    logic [AW-1:0]              alloc_addr;
    logic                       flush;
    logic [AW:0]                pend_cnt;

    modport master (
        output we, wa, wd, ra, alloc_en, alloc_addr, flush,
        input  rd, rdy, pend_cnt
    );

    modport slave (
        input  we, wa, wd, ra, alloc_en, alloc_addr, flush,
        output rd, rdy, pend_cnt
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-producer tracking: one bit per register, operand-ready
// per read port and a registered count of pending registers.
module regfile_scoreboard #(
    parameter int NREG = 32,
    parameter int NRP  = 3,
    parameter int NWP  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NWP-1:0]         we,
    input  logic [NWP-1:0][AW-1:0] wa,
    input  logic [NRP-1:0][AW-1:0] ra,
    input  logic                   alloc_en,
    input  logic [AW-1:0]          alloc_addr,
    input  logic                   flush,
    output logic [NRP-1:0]         rdy,
    output logic [AW:0]            pend_cnt
);

    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    logic [AW:0]     cnt_nxt;

    // Alloc is applied last so a new producer overrides a same-cycle write.
    always_comb begin
        pend_nxt = flush ? '0 : pend;
        for (int j = 0; j < NWP; j++)
            if (we[j]) pend_nxt[wa[j]] = 1'b0;
        if (alloc_en && alloc_addr != '0)
            pend_nxt[alloc_addr] = 1'b1;
        pend_nxt[0] = 1'b0;
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++)
            cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        rdy = '0;
        for (int i = 0; i < NRP; i++) begin
            rdy[i] = (ra[i] == '0) || !pend[ra[i]];
            for (int j = 0; j < NWP; j++)
                if (!rst && we[j] && wa[j] == ra[i])
                    rdy[i] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-through read bypass and
// an operand scoreboard; register 0 is hardwired to zero.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int NREG   = RF_NREG,
    parameter int NRP    = RF_NRP,
    parameter int NWP    = RF_NWP,
    parameter int SP_IDX = RF_SP_IDX,
    parameter logic [DATA_W-1:0] SP_INIT = RF_SP_INIT
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    localparam int AW = $clog2(NREG);

    logic [DATA_W-1:0]          mem [NREG];
    logic [NRP-1:0][DATA_W-1:0] rd_c;

    // Later ports are applied last, so the highest index wins a conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                mem[i] <= (i == SP_IDX) ? SP_INIT : '0;
        end else begin
            for (int j = 0; j < NWP; j++)
                if (bus.we[j] && bus.wa[j] != '0)
                    mem[bus.wa[j]] <= bus.wd[j];
        end
    end

    always_comb begin
        rd_c = '0;
        for (int i = 0; i < NRP; i++) begin
            rd_c[i] = mem[bus.ra[i]];
            for (int j = 0; j < NWP; j++)
                if (!rst && bus.we[j] &&
                    bus.wa[j] == bus.ra[i] && bus.ra[i] != '0)
                    rd_c[i] = bus.wd[j];
        end
    end

    assign bus.rd = rd_c;

    regfile_scoreboard #(
        .NREG (NREG),
        .NRP  (NRP),
        .NWP  (NWP)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .we         (bus.we),
        .wa         (bus.wa),
        .ra         (bus.ra),
        .alloc_en   (bus.alloc_en),
        .alloc_addr (bus.alloc_addr),
        .flush      (bus.flush),
        .rdy        (bus.rdy),
        .pend_cnt   (bus.pend_cnt)
    );

    logic [AW-1:0] unused_aw;
    assign unused_aw = '0;

endmodule
